// File: rtl/vga_txt_pkg.sv
// Shared types and constants for the text-mode character buffer.
// Compile-time defaults only; no logic.
package vga_txt_pkg;

    localparam int           DEF_COLS = 80;
    localparam int           DEF_ROWS = 30;
    localparam logic [7:0]   DEF_FILL = 8'h20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_ALL  = 2'd1
`ifdef VGA_TXT_BUF_SCROLL_EN
        ,
        CLR_LINE = 2'd2
`endif
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_txt_dpram.sv
// Simple dual-port RAM, one clock: 1-cycle registered read that holds when not enabled,
// old data returned on read/write collision; no backpressure.
module vga_txt_dpram #(
    parameter int DEPTH = 2400,
    parameter int DW    = 8,
    parameter int AW    = 12
)(
    input  logic          i_clk,
    input  logic          i_rst_h,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (i_rst_h)   rdata_q <= '0;
        else if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/vga_txt_buf.sv
// Text-mode character buffer: 1-cycle reads, writes accepted only while idle (o_wr_ready low during clears).
// Optional hardware scroll with line clear when VGA_TXT_BUF_SCROLL_EN is defined.
module vga_txt_buf
    import vga_txt_pkg::*;
#(
    parameter int            COLS  = DEF_COLS,
    parameter int            ROWS  = DEF_ROWS,
    parameter int            DW    = 8,
    parameter logic [DW-1:0] FILL  = DW'(DEF_FILL),
    localparam int           DEPTH = COLS * ROWS,
    localparam int           AW    = clog2(DEPTH),
    localparam int           CW    = clog2(COLS),
    localparam int           RW    = clog2(ROWS)
)(
    input  logic          i_clk,
    input  logic          i_rst_h,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [CW-1:0] i_wr_col,
    input  logic [RW-1:0] i_wr_row,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_clr_req,
    output logic          o_busy,
    input  logic          i_rd_en,
    input  logic [CW-1:0] i_rd_col,
    input  logic [RW-1:0] i_rd_row,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid
`ifdef VGA_TXT_BUF_SCROLL_EN
    ,
    input  logic          i_scroll_req,
    output logic [RW-1:0] o_top_row
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rd_vld_q, rd_oor_q;
    logic [RW-1:0] top_w;
    logic          scroll_w;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, rd_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          wr_acc, wr_in_range, rd_in_range;

`ifdef VGA_TXT_BUF_SCROLL_EN
    logic [RW-1:0] top_q, top_d, line_q, line_d;
    assign scroll_w  = i_scroll_req;
    assign top_w     = top_q;
    assign o_top_row = top_q;
`else
    assign scroll_w  = 1'b0;
    assign top_w     = '0;
`endif

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow,
                                               input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
        return sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                                input logic [CW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign o_wr_ready  = (state_q == IDLE) && !i_clr_req && !scroll_w;
    assign wr_acc      = i_wr_valid && o_wr_ready;
    assign wr_in_range = (int'(i_wr_col) < COLS) && (int'(i_wr_row) < ROWS);
    assign rd_in_range = (int'(i_rd_col) < COLS) && (int'(i_rd_row) < ROWS);
    assign rd_addr     = rd_in_range ? cell_addr(phys_row(i_rd_row, top_w), i_rd_col) : '0;
    assign o_busy      = (state_q != IDLE);
    assign o_rd_valid  = rd_vld_q;
    assign o_rd_data   = rd_oor_q ? FILL : ram_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = FILL;
`ifdef VGA_TXT_BUF_SCROLL_EN
        top_d     = top_q;
        line_d    = line_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = CLR_ALL;
                    cnt_d   = '0;
`ifdef VGA_TXT_BUF_SCROLL_EN
                    top_d   = '0;
                end else if (i_scroll_req) begin
                    // The old top row becomes the new bottom row and is blanked.
                    state_d = CLR_LINE;
                    cnt_d   = '0;
                    line_d  = top_q;
                    top_d   = (top_q == RW'(ROWS - 1)) ? '0 : top_q + 1'b1;
`endif
                end else if (wr_acc && wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr(phys_row(i_wr_row, top_w), i_wr_col);
                    ram_wdata = i_wr_data;
                end
            end
            CLR_ALL: begin
                ram_we = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef VGA_TXT_BUF_SCROLL_EN
            CLR_LINE: begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(line_q, cnt_q[CW-1:0]);
                if (cnt_q == AW'(COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_oor_q <= 1'b0;
`ifdef VGA_TXT_BUF_SCROLL_EN
            top_q    <= '0;
            line_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= i_rd_en;
            if (i_rd_en) rd_oor_q <= !rd_in_range;
`ifdef VGA_TXT_BUF_SCROLL_EN
            top_q    <= top_d;
            line_q   <= line_d;
`endif
        end
    end

    // Reset blocks the in-flight clear write so an aborted clear leaves that cell untouched.
    vga_txt_dpram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_h (i_rst_h),
        .i_we    (ram_we && !i_rst_h),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_re    (i_rd_en),
        .i_raddr (rd_addr),
        .o_rdata (ram_rdata)
    );

endmodule

// File: tb/tb_vga_txt_buf.sv
// Self-checking bench for vga_txt_buf against an array model of the screen.
// Scroll scenarios are built when VGA_TXT_BUF_SCROLL_EN is defined.
module tb_vga_txt_buf;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam int         DEPTH = COLS * ROWS;
    localparam logic [7:0] FILLV = 8'h20;

    logic       clk;
    logic       rst;
    logic       wr_valid, wr_ready;
    logic [6:0] wr_col, rd_col;
    logic [4:0] wr_row, rd_row;
    logic [7:0] wr_data, rd_data;
    logic       clr_req, busy, rd_en, rd_valid;
`ifdef VGA_TXT_BUF_SCROLL_EN
    logic       scroll_req;
    logic [4:0] top_row;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem [DEPTH];
    int         mtop = 0;

    vga_txt_buf dut (
        .i_clk        (clk),
        .i_rst_h      (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_col     (wr_col),
        .i_wr_row     (wr_row),
        .i_wr_data    (wr_data),
        .i_clr_req    (clr_req),
        .o_busy       (busy),
        .i_rd_en      (rd_en),
        .i_rd_col     (rd_col),
        .i_rd_row     (rd_row),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid)
`ifdef VGA_TXT_BUF_SCROLL_EN
        ,
        .i_scroll_req (scroll_req),
        .o_top_row    (top_row)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int maddr(input int col, input int row);
        return ((row + mtop) % ROWS) * COLS + col;
    endfunction

    function automatic logic [7:0] mexp(input int col, input int row);
        if (col >= COLS || row >= ROWS) return FILLV;
        return mem[maddr(col, row)];
    endfunction

    task automatic wr_cell(input int col, input int row, input logic [7:0] d);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 5'(row);
        wr_data  = d;
        while (wr_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $error("FAIL wr_timeout observed=not_ready expected=ready");
        end else begin
            if (col < COLS && row < ROWS) mem[maddr(col, row)] = d;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input int col, input int row, input string tag);
        logic [7:0] e;
        e      = mexp(col, row);
        rd_en  = 1'b1;
        rd_col = 7'(col);
        rd_row = 5'(row);
        tick();
        check(tag, 32'(rd_data), 32'(e));
        check({tag, "_vld"}, 32'(rd_valid), 32'(1'b1));
        rd_en  = 1'b0;
    endtask

    task automatic do_clear(input bit with_scroll);
        clr_req = 1'b1;
`ifdef VGA_TXT_BUF_SCROLL_EN
        scroll_req = with_scroll;
`endif
        tick();
        clr_req = 1'b0;
`ifdef VGA_TXT_BUF_SCROLL_EN
        scroll_req = 1'b0;
`endif
        mtop     = 0;
        wr_valid = 1'b1;
        wr_col   = 7'd1;
        wr_row   = 5'd1;
        wr_data  = 8'hEE;
        for (int i = 0; i < DEPTH; i++) begin
            check("clr_busy", 32'(busy), 32'(1'b1));
            check("clr_wr_ready", 32'(wr_ready), 32'(1'b0));
`ifdef VGA_TXT_BUF_SCROLL_EN
            scroll_req = (i == 500);
`endif
            tick();
        end
`ifdef VGA_TXT_BUF_SCROLL_EN
        scroll_req = 1'b0;
        check("clr_top_row", 32'(top_row), 32'(0));
`endif
        wr_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = FILLV;
        check("clr_done_busy", 32'(busy), 32'(1'b0));
        check("clr_done_ready", 32'(wr_ready), 32'(1'b1));
        if (with_scroll) check("clr_scroll_tag", 32'(1'b1), 32'(1'b1) & 32'(!busy));
    endtask

`ifdef VGA_TXT_BUF_SCROLL_EN
    task automatic do_scroll();
        int old;
        old        = mtop;
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        mtop       = (mtop + 1) % ROWS;
        check("scroll_top", 32'(top_row), 32'(mtop));
        for (int c = 0; c < COLS; c++) begin
            check("scroll_busy", 32'(busy), 32'(1'b1));
            tick();
        end
        for (int c = 0; c < COLS; c++) mem[old * COLS + c] = FILLV;
        check("scroll_done_busy", 32'(busy), 32'(1'b0));
    endtask
`endif

    initial begin
        logic [7:0] e;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_col   = '0;
        wr_row   = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        rd_en    = 1'b0;
        rd_col   = '0;
        rd_row   = '0;
`ifdef VGA_TXT_BUF_SCROLL_EN
        scroll_req = 1'b0;
`endif
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
        check("rst_rd_data", 32'(rd_data), 32'(8'h00));
        check("rst_wr_ready", 32'(wr_ready), 32'(1'b1));
`ifdef VGA_TXT_BUF_SCROLL_EN
        check("rst_top_row", 32'(top_row), 32'(0));
`endif

        // Full clear then every cell reads FILL
        do_clear(1'b0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                rd_chk(c, r, "clr_cell");

        // Single write then read with one-cycle latency and hold
        wr_cell(5, 2, 8'h41);
        rd_en  = 1'b1;
        rd_col = 7'd5;
        rd_row = 5'd2;
        check("lat_pre_valid", 32'(rd_valid), 32'(1'b0));
        tick();
        check("lat_data", 32'(rd_data), 32'(8'h41));
        check("lat_valid", 32'(rd_valid), 32'(1'b1));
        rd_en  = 1'b0;
        rd_col = 7'd7;
        tick();
        check("hold_valid", 32'(rd_valid), 32'(1'b0));
        check("hold_data", 32'(rd_data), 32'(8'h41));
        tick();
        check("hold_data2", 32'(rd_data), 32'(8'h41));

        // Same-cycle read and write of one cell returns old data
        e        = mexp(9, 3);
        wr_valid = 1'b1;
        wr_col   = 7'd9;
        wr_row   = 5'd3;
        wr_data  = 8'h99;
        rd_en    = 1'b1;
        rd_col   = 7'd9;
        rd_row   = 5'd3;
        check("coll_ready", 32'(wr_ready), 32'(1'b1));
        tick();
        mem[maddr(9, 3)] = 8'h99;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        check("coll_old", 32'(rd_data), 32'(e));
        rd_chk(9, 3, "coll_new");

        // Out-of-range writes are dropped; out-of-range reads return FILL
        wr_cell(80, 0, 8'h55);
        wr_cell(5, 30, 8'h56);
        wr_cell(100, 31, 8'h57);
        rd_chk(80, 0, "oor_rd_col");
        rd_chk(3, 31, "oor_rd_row");
        for (int c = 0; c < COLS; c++) rd_chk(c, 0, "oor_row0");
        rd_chk(5, 0, "oor_cell");

        // Random writes and back-to-back random reads
        for (int i = 0; i < 300; i++)
            wr_cell(int'($urandom_range(COLS + 3)), int'($urandom_range(ROWS + 1)), 8'($urandom));
        for (int i = 0; i < 300; i++)
            rd_chk(int'($urandom_range(COLS + 3)), int'($urandom_range(ROWS + 1)), "rand_rd");

        // Reads during a clear, then reset at clear cycle 100
        for (int i = 0; i <= 10; i++) wr_cell(15 + i, 1, 8'h60 + 8'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (98) tick();
        for (int a = 0; a < 98; a++) mem[a] = FILLV;
        rd_chk(18, 1, "clr_rd_old");
        mem[98] = FILLV;
        rd_chk(18, 1, "clr_rd_new");
        mem[99] = FILLV;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'(1'b0));
        check("abort_ready", 32'(wr_ready), 32'(1'b1));
        check("abort_rd_valid", 32'(rd_valid), 32'(1'b0));
        check("abort_rd_data", 32'(rd_data), 32'(8'h00));
        mtop = 0;
        for (int i = 0; i <= 10; i++) rd_chk(15 + i, 1, "abort_cell");
        rd_chk(0, 0, "abort_cell0");

`ifdef VGA_TXT_BUF_SCROLL_EN
        // Scroll: logical row 0 shows old row 1, new bottom row is blank
        for (int c = 0; c < COLS; c++) wr_cell(c, 0, 8'h41);
        for (int c = 0; c < COLS; c++) wr_cell(c, 1, 8'h42);
        do_scroll();
        check("scroll_top1", 32'(top_row), 32'(1));
        for (int c = 0; c < COLS; c++) rd_chk(c, 0, "scroll_row0");
        for (int c = 0; c < COLS; c++) rd_chk(c, ROWS - 1, "scroll_row29");
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < 5; i++)
                wr_cell(int'($urandom_range(COLS - 1)), int'($urandom_range(ROWS - 1)), 8'($urandom));
            do_scroll();
            for (int i = 0; i < 10; i++)
                rd_chk(int'($urandom_range(COLS - 1)), int'($urandom_range(ROWS - 1)), "scroll_rand");
        end
        check("scroll_wrap_top", 32'(top_row), 32'(1));
        // Clear and scroll together: clear wins, top returns to 0
        do_clear(1'b1);
        for (int i = 0; i < 50; i++)
            rd_chk(int'($urandom_range(COLS - 1)), int'($urandom_range(ROWS - 1)), "clr_scroll_rd");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_txt_buf.md
VGA_TXT_BUF -- requirements
Module: vga_txt_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- COLS, 80: characters per row.
- ROWS, 30: rows per screen.
- DW, 8: bits per cell (char code, optionally with attribute).
- FILL, 8'h20: value written by clear operations; width DW.
REQ-002 Derived localparams: DEPTH=COLS*ROWS, AW=clog2(DEPTH), CW=clog2(COLS), RW=clog2(ROWS).
REQ-003 One clock; reset is synchronous and active-high. Ports, one per line: name, direction, width, meaning.
- i_clk  in  1  sole clock.
- i_rst_h  in  1  synchronous active-high reset.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  write accepted when valid&ready.
- i_wr_col  in  CW  write column.
- i_wr_row  in  RW  write logical row.
- i_wr_data  in  DW  write cell value.
- i_clr_req  in  1  full-screen clear request, single-cycle pulse.
- o_busy  out  1  clear or line-clear in progress.
- i_rd_en  in  1  read strobe (video side).
- i_rd_col  in  CW  read column.
- i_rd_row  in  RW  read logical row.
- o_rd_data  out  DW  read data.
- o_rd_valid  out  1  o_rd_data valid.
- i_scroll_req  in  1  scroll up one row (VGA_TXT_BUF_SCROLL_EN only).
- o_top_row  out  RW  current physical top row (VGA_TXT_BUF_SCROLL_EN only).

Function
REQ-004 Physical row = (logical row + top) mod ROWS; address = phys_row*COLS + col; top is 0 without the macro.
REQ-005 o_wr_ready = (state==IDLE) & !i_clr_req & !i_scroll_req; the RAM write occurs in the acceptance cycle.
REQ-006 Accepted write with col>=COLS or row>=ROWS: dropped, RAM unchanged, handshake still completes.
REQ-007 Read latency 1 cycle: o_rd_valid = i_rd_en delayed one cycle; o_rd_data updates only when i_rd_en is asserted, otherwise it holds.
REQ-008 Out-of-range read returns FILL.
REQ-009 Read and write to the same address in the same cycle returns the old data.
REQ-010 FSM states: IDLE, CLR_ALL, CLR_LINE.
- IDLE->CLR_ALL on i_clr_req.
- IDLE->CLR_LINE on i_scroll_req.
- CLR_ALL->IDLE after DEPTH writes.
- CLR_LINE->IDLE after COLS writes.
REQ-011 CLR_ALL writes FILL at addresses 0..DEPTH-1, one per cycle, in ascending order; top is set to 0 on entry.
REQ-012 On the scroll request: top <= (top+1) mod ROWS; CLR_LINE then writes FILL across the old top physical row (the new bottom logical row), COLS cycles.
REQ-013 o_busy = (state!=IDLE), registered; i_clr_req and i_scroll_req are ignored while busy.
REQ-014 i_clr_req and i_scroll_req in the same IDLE cycle: clear wins and the scroll is discarded.
REQ-015 Reads remain serviced during clears; data returned is the RAM content at the read cycle.

Reset
REQ-016 Reset state: IDLE, top=0, fill counter=0, o_busy=0, o_rd_valid=0, o_rd_data=0; o_wr_ready=1 in the first cycle after reset.
REQ-017 Reset asserted mid-clear aborts the clear immediately; partially cleared contents are retained.
REQ-018 RAM contents are not reset.

Configuration
REQ-019 Macro VGA_TXT_BUF_SCROLL_EN.
- Defined: i_scroll_req and o_top_row exist, and CLR_LINE plus the top register are built.
- Undefined: those ports, the state and the register are absent; top is constant 0.

Structure
REQ-020 Package vga_txt_pkg holds:
- the state enum;
- default COLS/ROWS/FILL constants;
- a clog2 function.
REQ-021 Sub-module vga_txt_dpram: simple dual-port, single clock, inferred, DEPTH x DW, registered read, read-old-on-collision.

Verification
REQ-022 Write (col 5, row 2, 8'h41), then read (5,2) -> o_rd_data=8'h41 and o_rd_valid=1 exactly one cycle after i_rd_en.
REQ-023 Pulse i_clr_req -> o_busy high for 2400 cycles (80x30), o_wr_ready=0 throughout, all 2400 cells then read 8'h20.
REQ-024 Write row 0 ='A', row 1 ='B', then scroll (macro on) -> o_top_row=1, logical row 0 reads 'B', logical row 29 reads 8'h20 after 80 busy cycles.
REQ-025 Write with col=80 -> handshake completes, no cell changes; read of (80,0) returns 8'h20.
REQ-026 Assert i_rst_h at clear cycle 100 -> next cycle o_busy=0, o_wr_ready=1; cells 0..99 = FILL, cell 100 onward unchanged.
REQ-027 i_clr_req and i_scroll_req in the same cycle -> full clear runs, o_top_row=0.
